// File: rtl/board_io_v2.sv
// Board I/O: switch synchroniser/debouncer, probe-select hex display, sticky error capture.
// Define BOARD_IO_SCAN_EN to add the multiplexed-display outputs seg_scan/an_n.
module board_io_v2 #(
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned NUM_PROBES      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ERR_WIDTH       = 8,
    parameter int unsigned SCAN_CYCLES     = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [SW_WIDTH-1:0]                  switch_array,
    input  logic [NUM_PROBES*4*NUM_DIGITS-1:0]   probe_data,
    input  logic                                 display_hold,
    input  logic [ERR_WIDTH-1:0]                 err_in,
    input  logic                                 err_clear,
    output logic [SW_WIDTH-1:0]                  sw_stable,
    output logic                                 sw_changed,
    output logic [7*NUM_DIGITS-1:0]              seg,
    output logic [ERR_WIDTH-1:0]                 toplevel_error_vector,
    output logic                                 err_valid,
    output logic [$clog2(ERR_WIDTH)-1:0]         err_first
`ifdef BOARD_IO_SCAN_EN
    ,
    output logic [6:0]                           seg_scan,
    output logic [NUM_DIGITS-1:0]                an_n
`endif
);

    localparam int unsigned PW     = 4 * NUM_DIGITS;
    localparam int unsigned PSEL_W = $clog2(NUM_PROBES);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned EF_W   = $clog2(ERR_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] GLYPH_0 = 7'b1000000;

    logic [SW_WIDTH-1:0]   r_sync1, r_sync2, r_stable, w_stable_nxt;
    logic [CNT_W-1:0]      r_cnt [SW_WIDTH];
    logic                  r_changed;
    logic [PSEL_W-1:0]     w_psel;
    logic [PW-1:0]         r_snap;
    logic [7*NUM_DIGITS-1:0] r_seg, w_seg_nxt;
    logic [ERR_WIDTH-1:0]  r_vec, w_vec_nxt;
    logic                  r_valid, w_valid_base, w_valid_nxt;
    logic [EF_W-1:0]       r_first, w_first_base, w_first_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    function automatic logic [EF_W-1:0] lowest_set(input logic [ERR_WIDTH-1:0] v);
        logic found;
        found      = 1'b0;
        lowest_set = '0;
        for (int unsigned i = 0; i < ERR_WIDTH; i++) begin
            if (v[i] && !found) begin
                found      = 1'b1;
                lowest_set = EF_W'(i);
            end
        end
    endfunction

    // A bit flips only after its counter has seen DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int unsigned i = 0; i < SW_WIDTH; i++) begin
            if (r_sync2[i] != r_stable[i] && r_cnt[i] == CNT_MAX)
                w_stable_nxt[i] = r_sync2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_changed <= 1'b0;
            for (int unsigned i = 0; i < SW_WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1   <= switch_array;
            r_sync2   <= r_sync1;
            r_stable  <= w_stable_nxt;
            r_changed <= |(w_stable_nxt ^ r_stable);
            for (int unsigned i = 0; i < SW_WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i] || r_cnt[i] == CNT_MAX)
                    r_cnt[i] <= '0;
                else
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    assign w_psel = r_stable[SW_WIDTH-1 -: PSEL_W];

    always_comb begin
        w_seg_nxt = '0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++)
            w_seg_nxt[7*d +: 7] = hex7(r_snap[4*d +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap <= '0;
            r_seg  <= {NUM_DIGITS{GLYPH_0}};
        end else begin
            if (!display_hold) r_snap <= probe_data[w_psel*PW +: PW];
            r_seg <= w_seg_nxt;
        end
    end

    // A clear is applied first, so errors arriving with it are captured as the new first error.
    always_comb begin
        w_vec_nxt    = err_clear ? err_in : (r_vec | err_in);
        w_valid_base = err_clear ? 1'b0 : r_valid;
        w_first_base = err_clear ? '0 : r_first;
        w_valid_nxt  = w_valid_base;
        w_first_nxt  = w_first_base;
        if (!w_valid_base && |err_in) begin
            w_valid_nxt = 1'b1;
            w_first_nxt = lowest_set(err_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec   <= '0;
            r_valid <= 1'b0;
            r_first <= '0;
        end else begin
            r_vec   <= w_vec_nxt;
            r_valid <= w_valid_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign sw_stable             = r_stable;
    assign sw_changed            = r_changed;
    assign seg                   = r_seg;
    assign toplevel_error_vector = r_vec;
    assign err_valid             = r_valid;
    assign err_first             = r_first;

`ifdef BOARD_IO_SCAN_EN
    localparam int unsigned DW    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DW-1:0]         r_dwell;
    logic [DIG_W-1:0]      r_digit, w_digit_nxt;
    logic                  w_dwell_end;
    logic [6:0]            r_seg_scan;
    logic [NUM_DIGITS-1:0] r_an_n;

    assign w_dwell_end = (r_dwell == DW'(SCAN_CYCLES - 1));

    always_comb begin
        w_digit_nxt = r_digit;
        if (w_dwell_end)
            w_digit_nxt = (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell    <= '0;
            r_digit    <= '0;
            r_an_n     <= ~NUM_DIGITS'(1);
            r_seg_scan <= GLYPH_0;
        end else begin
            r_dwell    <= w_dwell_end ? '0 : r_dwell + 1'b1;
            r_digit    <= w_digit_nxt;
            r_an_n     <= ~(NUM_DIGITS'(1) << w_digit_nxt);
            r_seg_scan <= r_seg[w_digit_nxt*7 +: 7];
        end
    end

    assign seg_scan = r_seg_scan;
    assign an_n     = r_an_n;
`endif

endmodule

// File: tb/tb_board_io_v2.sv
// Directed self-checking bench for board_io_v2 (DEBOUNCE_CYCLES=4, SCAN_CYCLES=4).
module tb_board_io_v2;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  switch_array;
    logic [127:0] probe_data;
    logic         display_hold;
    logic [7:0]   err_in;
    logic         err_clear;
    logic [15:0]  sw_stable;
    logic         sw_changed;
    logic [55:0]  seg;
    logic [7:0]   toplevel_error_vector;
    logic         err_valid;
    logic [2:0]   err_first;
`ifdef BOARD_IO_SCAN_EN
    logic [6:0]   seg_scan;
    logic [7:0]   an_n;
    logic [7:0]   an_exp;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [55:0] SEG_RST = {8{7'b1000000}};

    board_io_v2 #(
        .SW_WIDTH(16), .NUM_DIGITS(8), .NUM_PROBES(4),
        .DEBOUNCE_CYCLES(4), .ERR_WIDTH(8), .SCAN_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .switch_array(switch_array), .probe_data(probe_data),
        .display_hold(display_hold), .err_in(err_in), .err_clear(err_clear),
        .sw_stable(sw_stable), .sw_changed(sw_changed), .seg(seg),
        .toplevel_error_vector(toplevel_error_vector), .err_valid(err_valid),
        .err_first(err_first)
`ifdef BOARD_IO_SCAN_EN
        , .seg_scan(seg_scan), .an_n(an_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; switch_array = '0; probe_data = '0; display_hold = 1'b0;
        err_in = '0; err_clear = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_seg", seg, SEG_RST);
        chk("rst_sw_stable", sw_stable, 0);
        chk("rst_sw_changed", sw_changed, 0);
        chk("rst_vec", toplevel_error_vector, 0);
        chk("rst_valid", err_valid, 0);
        chk("rst_first", err_first, 0);
`ifdef BOARD_IO_SCAN_EN
        chk("scan_an_rst", an_n, 8'hFE);
        for (int d = 1; d <= 8; d++) begin
            step(4);
            an_exp = ~(8'd1 << (d % 8));
            chk("scan_an", an_n, an_exp);
            chk("scan_seg", seg_scan, 7'b1000000);
        end
`endif

        // Debounce: 2 sync + 4 stable cycles before sw_stable moves
        probe_data[31:0] = 32'h7654_3210;
        switch_array[0] = 1'b1;
        step(5);
        chk("db_early_stable", sw_stable, 16'h0000);
        chk("db_early_pulse", sw_changed, 0);
        step(1);
        chk("db_stable", sw_stable, 16'h0001);
        chk("db_pulse", sw_changed, 1);
        step(1);
        chk("db_pulse_end", sw_changed, 0);
        chk("probe0_d0", seg[6:0], 7'b1000000);
        chk("probe0_d3", seg[27:21], 7'b0110000);
        chk("probe0_d7", seg[55:49], 7'b1111000);

        // 3-cycle glitch is ignored
        switch_array[1] = 1'b1;
        step(3);
        switch_array[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("glitch_pulse", sw_changed, 0);
            step(1);
        end
        chk("glitch_stable", sw_stable, 16'h0001);

        // Probe select via upper switches
        probe_data[95:64] = 32'h1234_ABCD;
        switch_array[15:14] = 2'b10;
        step(6);
        chk("psel_stable", sw_stable, 16'h8001);
        step(1);
        chk("psel_lat_d0", seg[6:0], 7'b1000000);
        step(1);
        chk("psel_d0", seg[6:0], 7'b0100001);
        chk("psel_d2", seg[20:14], 7'b0000011);
        chk("psel_d3", seg[27:21], 7'b0001000);
        chk("psel_d7", seg[55:49], 7'b1111001);

        // Probe-to-seg latency is two cycles
        probe_data[95:64] = 32'h1234_ABCE;
        step(1);
        chk("lat1_d0", seg[6:0], 7'b0100001);
        step(1);
        chk("lat2_d0", seg[6:0], 7'b0000110);

        // Hold freezes the snapshot
        display_hold = 1'b1;
        probe_data[95:64] = 32'hFFFF_FFFF;
        step(3);
        chk("hold_d0", seg[6:0], 7'b0000110);
        chk("hold_d7", seg[55:49], 7'b1111001);
        display_hold = 1'b0;
        step(2);
        chk("release_d0", seg[6:0], 7'b0001110);
        chk("release_d7", seg[55:49], 7'b0001110);

        // Sticky errors and first-error capture
        err_in = 8'h28;
        step(1);
        chk("err1_vec", toplevel_error_vector, 8'h28);
        chk("err1_first", err_first, 3);
        err_in = 8'h01;
        step(1);
        err_in = 8'h00;
        chk("err2_vec", toplevel_error_vector, 8'h29);
        chk("err2_first", err_first, 3);
        chk("err2_valid", err_valid, 1);
        err_clear = 1'b1; err_in = 8'h40;
        step(1);
        err_clear = 1'b0; err_in = 8'h00;
        chk("clr_new_vec", toplevel_error_vector, 8'h40);
        chk("clr_new_first", err_first, 6);
        chk("clr_new_valid", err_valid, 1);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        chk("clr_vec", toplevel_error_vector, 8'h00);
        chk("clr_valid", err_valid, 0);
        chk("clr_first", err_first, 0);
        err_in = 8'hFF;
        step(1);
        err_in = 8'h00;
        chk("ff_vec", toplevel_error_vector, 8'hFF);
        chk("ff_first", err_first, 0);

        // Reset mid-debounce discards pending change
        switch_array = 16'h8004;
        step(3);
        rst = 1'b1;
        step(1);
        chk("mrst_stable", sw_stable, 16'h0000);
        chk("mrst_pulse", sw_changed, 0);
        chk("mrst_seg", seg, SEG_RST);
        chk("mrst_vec", toplevel_error_vector, 8'h00);
        chk("mrst_valid", err_valid, 0);
        chk("mrst_first", err_first, 0);
        rst = 1'b0;
        step(5);
        chk("mrst_restart_early", sw_stable, 16'h0000);
        step(1);
        chk("mrst_restart_stable", sw_stable, 16'h8004);
        chk("mrst_restart_pulse", sw_changed, 1);
        step(1);
        chk("mrst_restart_pulse_end", sw_changed, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
